// File: rtl/fbank_lut_reader_if.sv
// Power-sample input stream and mel-band output stream of the filterbank reader.
// Latency: none, wiring only.
// Backpressure: pwr_ready throttles the input side; the mel side has no ready.
interface fbank_lut_reader_if #(
    parameter int PWR_W = 32,
    parameter int ACC_W = 40
);
    logic             pwr_valid;
    logic             pwr_ready;
    logic [PWR_W-1:0] pwr_data;
    logic             pwr_last;
    logic             mel_valid;
    logic [ACC_W-1:0] mel_data;
    logic [5:0]       mel_idx;
    logic             mel_last;

    modport master (
        output pwr_valid, pwr_data, pwr_last,
        input  pwr_ready, mel_valid, mel_data, mel_idx, mel_last
    );

    modport slave (
        input  pwr_valid, pwr_data, pwr_last,
        output pwr_ready, mel_valid, mel_data, mel_idx, mel_last
    );
endinterface

// File: rtl/fbank_lut_reader.sv
// Splits each power bin across two overlapping mel bands using LUT weights, emits band energies.
// Latency: band energy appears 3 cycles after the bin carrying the closing centre flag is accepted.
// Backpressure: pwr_ready drops for the 3-cycle pipeline drain at frame end; output is never stalled.
module fbank_lut_reader #(
    parameter int N_BINS  = 512,
    parameter int N_BANDS = 40,
    parameter int PWR_W   = 32,
    parameter int ACC_W   = 40
) (
    input  logic              clk,
    input  logic              rst,
    fbank_lut_reader_if.slave strm,
    output logic [9:0]        lut_addr,
    output logic              lut_wr_en,
    output logic [16:0]       lut_wr_data,
    input  logic [16:0]       lut_rd_data,
    output logic              frame_err
);
    localparam logic [9:0]       LAST_BIN  = 10'(N_BINS - 1);
    localparam logic [9:0]       NB        = 10'(N_BANDS);
    localparam logic [9:0]       BAND_END  = 10'(N_BANDS + 1);
    localparam logic [9:0]       LAST_IDX  = 10'(N_BANDS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [1:0]        flush_cnt;
    logic              accept, end_bin, flush_done;
    logic [9:0]        bin_cnt, band_cnt, band_idx;
    logic              v0, v1, flag1, emit;
    logic [PWR_W-1:0]  p_d, hi, lo;
    logic [PWR_W+15:0] prod_hi, prod_lo;
    logic [ACC_W-1:0]  acc_cur, acc_nxt, cur_upd, nxt_upd;
    logic [ACC_W:0]    cur_sum, nxt_sum;

    // The LUT is read-only from this side.
    assign lut_wr_en   = 1'b0;
    assign lut_wr_data = '0;
    assign lut_addr    = bin_cnt;

    assign strm.pwr_ready = ~rst & (state != FLUSH);
    assign accept     = strm.pwr_valid & strm.pwr_ready;
    // A frame also ends when the bin counter reaches the last LUT entry, even without pwr_last.
    assign end_bin    = strm.pwr_last | (bin_cnt == LAST_BIN);
    assign flush_done = (state == FLUSH) && (flush_cnt == 2'd2);

    // S1: split delayed power with the LUT word that arrives one cycle after the address.
    assign prod_hi = {16'd0, p_d} * {{PWR_W{1'b0}}, lut_rd_data[15:0]};
    assign prod_lo = {16'd0, p_d} * {{PWR_W{1'b0}}, ~lut_rd_data[15:0]};

    // S2: saturating band accumulation; a centre flag closes the current band.
    assign nxt_sum  = {1'b0, acc_nxt} + {{(ACC_W - PWR_W + 1){1'b0}}, hi};
    assign cur_sum  = {1'b0, acc_cur} + {{(ACC_W - PWR_W + 1){1'b0}}, lo};
    assign nxt_upd  = nxt_sum[ACC_W] ? ACC_MAX : nxt_sum[ACC_W-1:0];
    assign cur_upd  = cur_sum[ACC_W] ? ACC_MAX : cur_sum[ACC_W-1:0];
    assign band_idx = band_cnt - 10'd1;
    assign emit     = v1 & flag1 & (band_cnt != 10'd0) & (band_cnt <= NB);

    // State register plus drain timer for the 3-stage pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
        end
    end

    // Frame sequencing: start on first sample, drain after the last one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = end_bin ? FLUSH : RUN;
            RUN:     if (accept && end_bin) state_nxt = FLUSH;
            FLUSH:   if (flush_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pipeline, accumulators, counters, band output and error tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0             <= 1'b0;
            v1             <= 1'b0;
            p_d            <= '0;
            hi             <= '0;
            lo             <= '0;
            flag1          <= 1'b0;
            acc_cur        <= '0;
            acc_nxt        <= '0;
            bin_cnt        <= '0;
            band_cnt       <= '0;
            strm.mel_valid <= 1'b0;
            strm.mel_last  <= 1'b0;
            strm.mel_data  <= '0;
            strm.mel_idx   <= '0;
            frame_err      <= 1'b0;
        end else begin
            v0 <= accept;
            if (accept) begin
                p_d     <= strm.pwr_data;
                bin_cnt <= bin_cnt + 10'd1;
            end

            v1 <= v0;
            if (v0) begin
                hi    <= PWR_W'(prod_hi >> 16);
                lo    <= PWR_W'(prod_lo >> 16);
                flag1 <= lut_rd_data[16];
            end

            strm.mel_valid <= emit;
            strm.mel_last  <= emit && (band_idx == LAST_IDX);
            if (emit) begin
                strm.mel_data <= cur_upd;
                strm.mel_idx  <= band_idx[5:0];
            end

            if (v1) begin
                if (flag1) begin
                    acc_cur  <= nxt_upd;
                    acc_nxt  <= '0;
                    band_cnt <= band_cnt + 10'd1;
                end else begin
                    acc_cur  <= cur_upd;
                    acc_nxt  <= nxt_upd;
                end
            end

            // Residual energy of an incomplete band is dropped at frame end.
            if (flush_done) begin
                bin_cnt  <= '0;
                band_cnt <= '0;
                acc_cur  <= '0;
                acc_nxt  <= '0;
            end

            if (accept && (state == IDLE)) frame_err <= 1'b0;
            if ((accept && (bin_cnt == LAST_BIN) && !strm.pwr_last) ||
                (v1 && flag1 && (band_cnt >= BAND_END)) ||
                (flush_done && (band_cnt != BAND_END)))
                frame_err <= 1'b1;
        end
    end
endmodule

// File: doc/fbank_lut_reader.md
Name: fbank_lut_reader

Overview:
- Consumer side of the single-port mel filterbank coefficient LUT (17-bit words, 10-bit address). Holds the LUT's address port and tie-offs its write path.
- For each frame, streams power-spectrum bins in and reads one LUT word per bin, addressed by bin index.
- Splits each bin's power between two overlapping triangular mel bands and emits one accumulated energy per band to the log/DCT stage downstream.

Parameters:
- N_BINS, 512: spectrum bins per frame; LUT addresses 0..N_BINS-1.
- N_BANDS, 40: mel bands emitted per frame.
- PWR_W, 32: power sample width, unsigned.
- ACC_W, 40: band accumulator and output width, unsigned, saturating.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pwr_valid  in  1  power sample valid.
- pwr_ready  out  1  block accepts a sample this cycle.
- pwr_data  in  PWR_W  power of current bin.
- pwr_last  in  1  last bin of frame.
- lut_addr  out  10  LUT address.
- lut_wr_en  out  1  constant 0.
- lut_wr_data  out  17  constant 0.
- lut_rd_data  in  17  LUT word. Bit 16 is the center flag; bits 15:0 are the upper weight w, unsigned Q0.16.
- mel_valid  out  1  band energy valid, one-cycle pulse.
- mel_data  out  ACC_W  band energy.
- mel_idx  out  6  band index, 0..N_BANDS-1.
- mel_last  out  1  with final band of frame.
- frame_err  out  1  sticky error; cleared by rst or at next frame start.

Behaviour:
- Reset values:
  - pwr_ready=0 during rst, 1 in the first cycle after.
  - All other outputs 0; accumulators, counters and pipeline valids cleared.
  - rst mid-frame discards in-flight bins; no mel output follows.
- States:
  - IDLE→RUN on first accepted sample.
  - RUN→FLUSH on accepted pwr_last, or on the accepted sample with bin_cnt==N_BINS-1.
  - FLUSH drains the 3-stage pipeline, then returns to IDLE.
  - pwr_ready=0 only in FLUSH.
- Acceptance and LUT read:
  - A sample is accepted when pwr_valid & pwr_ready.
  - lut_addr = bin_cnt combinationally in the accept cycle. bin_cnt starts at 0 each frame and increments per accepted sample.
  - LUT read latency is 1, unregistered output; lut_rd_data is valid the next cycle alongside the delayed power.
- Pipeline:
  - S1 (accept+1): hi = (p*w)>>16 and lo = (p*(0xFFFF-w))>>16, both registered, PWR_W bits.
  - S2 (accept+2): acc_nxt += hi; acc_cur += lo. Both saturate at 2^ACC_W-1.
  - If flag=1 at S2 and band_cnt>0, the emitted value is the updated acc_cur.
  - Then, for any flag=1: acc_cur ← updated acc_nxt, acc_nxt ← 0, band_cnt++.
  - The first flag of a frame emits nothing.
  - mel_valid is registered at accept+3.
- Output:
  - mel_idx = band_cnt-1 at emission.
  - mel_last=1 when mel_idx==N_BANDS-1.
  - Flags beyond N_BANDS+1 are counted but emit nothing, and set frame_err.
- Frame-end checks: set frame_err if either
  - the frame ends with band_cnt != N_BANDS+1, or
  - pwr_last is absent when bin_cnt reaches N_BINS-1 (that bin is treated as last).
- Frame-end handling: residual accumulators are discarded; all counters and accumulators clear on entering IDLE.
- No output backpressure: the downstream consumer always accepts.
- Back-to-back frames are allowed after FLUSH.
- Throughput is 1 bin/cycle in RUN.

Test Plan:
- Reset: assert rst 2 cycles mid-stream.
  - Expected: all outputs 0, pwr_ready=0 during rst and 1 after.
  - Expected: no mel_valid from pre-reset bins.
- Basic frame: N_BINS=8, N_BANDS=2. LUT flags at bins 0,3,7 with w=0xFFFF; other bins flag=0, w=0x8000. pwr_data=0x100 on all 8 bins, pwr_last on bin 7.
  - Expected: mel_valid at bin3-accept+3 with data 0x1FD, idx 0.
  - Expected: mel_valid at bin7-accept+3 with data 0x37C, idx 1, mel_last=1.
  - Expected: frame_err=0.
- Gaps: same frame with pwr_valid toggling 1-0-1.
  - Expected: identical mel_data and idx.
  - Expected: lut_addr sequence 0..7 with no skips or repeats.
- Saturation: ACC_W=PWR_W, pwr_data all-ones, w=0x8000 over 3 bins.
  - Expected: the emitted band equals 2^ACC_W-1 with no wrap.
- Short frame: pwr_last at bin 5 with flags at 0 and 3.
  - Expected: one band emitted (0x1FD), frame_err=1, next frame clears frame_err.
- Overlong frame: 8 bins with no pwr_last.
  - Expected: bin 7 treated as last, frame_err=1, FLUSH then IDLE, pwr_ready=0 exactly 3 cycles.
